// File: rtl/hazard_forward_ctrl.sv
// Hazard controller for the 5-stage core: shadow EX/MEM/WB scoreboard, operand
// forwarding selects, load-use stall, branch flush, memory-wait freeze and event counters.
module hazard_forward_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic [3:0]       ID_Rn,
  input  logic [3:0]       ID_Rm,
  input  logic [3:0]       ID_Rd,
  input  logic             ID_use_Rn,
  input  logic             ID_use_Rm,
  input  logic             ID_use_Rd,
  input  logic             ID_RF_enable,
  input  logic             ID_load_instr,
  input  logic             branch_taken,
  input  logic             mem_wait,
  output logic             PC_LE,
  output logic             IFID_LE,
  output logic             IFID_flush,
  output logic             mux_e,
  output logic             pipe_hold,
  output logic [1:0]       fwd_A,
  output logic [1:0]       fwd_B,
  output logic [1:0]       fwd_D,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // state  | meaning
  // RUN    | pipe advances; hazards evaluated normally
  // FREEZE | data memory busy last cycle; whole pipe holds
  typedef enum logic {RUN, FREEZE} mode_t;

  typedef struct packed {
    logic       v;
    logic [3:0] rd;
    logic       rf;
    logic       ld;
  } sb_t;

  mode_t mode_q, mode_d;
  sb_t   ex_q, mem_q, wb_q;
  logic  frozen, lu, stall_inc, flush_inc;

  function automatic logic hit(input sb_t e, input logic [3:0] s);
    return e.v & e.rf & (e.rd == s) & (s != 4'hF);
  endfunction

  // EX results of a load are not available yet, so an EX load match falls through to older stages.
  function automatic logic [1:0] sel(input logic used, input logic [3:0] s,
                                     input sb_t ex, input sb_t mem, input sb_t wb);
    if (!used)                   return 2'b00;
    else if (hit(ex, s) && !ex.ld) return 2'b01;
    else if (hit(mem, s))        return 2'b10;
    else if (hit(wb, s))         return 2'b11;
    else                         return 2'b00;
  endfunction

  assign lu = ex_q.ld & ((ID_use_Rn & hit(ex_q, ID_Rn)) |
                         (ID_use_Rm & hit(ex_q, ID_Rm)) |
                         (ID_use_Rd & hit(ex_q, ID_Rd)));

  assign frozen = (mode_q == FREEZE) | mem_wait;
  assign mode_d = mem_wait ? FREEZE : RUN;

  always_comb begin
    PC_LE      = 1'b1;
    IFID_LE    = 1'b1;
    IFID_flush = 1'b0;
    mux_e      = 1'b0;
    pipe_hold  = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    fwd_A      = 2'b00;
    fwd_B      = 2'b00;
    fwd_D      = 2'b00;
    // Outputs are forced to their idle values while reset is held, whatever the inputs.
    if (Clr) begin
      fwd_A = sel(ID_use_Rn, ID_Rn, ex_q, mem_q, wb_q);
      fwd_B = sel(ID_use_Rm, ID_Rm, ex_q, mem_q, wb_q);
      fwd_D = sel(ID_use_Rd, ID_Rd, ex_q, mem_q, wb_q);
      if (frozen) begin
        PC_LE     = 1'b0;
        IFID_LE   = 1'b0;
        pipe_hold = 1'b1;
      end else if (lu) begin
        PC_LE     = 1'b0;
        IFID_LE   = 1'b0;
        mux_e     = 1'b1;
        stall_inc = 1'b1;
      end else if (branch_taken) begin
        IFID_flush = 1'b1;
        flush_inc  = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      mode_q    <= RUN;
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      mode_q <= mode_d;
      if (!frozen) begin
        ex_q  <= mux_e ? '0 : {1'b1, ID_Rd, ID_RF_enable, ID_load_instr};
        mem_q <= ex_q;
        wb_q  <= mem_q;
        if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
        if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule
